// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared definitions for the SPI slave core: default frame and
//               address widths and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    // Default data word / command frame length and address width.
    // The command frame is {addr[ADDR_W-1:0], rw}, so ADDR_W = WIDTH-1.
    localparam int unsigned c_default_width  = 8;
    localparam int unsigned c_default_addr_w = c_default_width - 1;

    // Controller states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_GET_ADDR     = 3'd1,
        ST_READ_LOAD    = 3'd2,
        ST_READ_SHIFT   = 3'd3,
        ST_WRITE_SHIFT  = 3'd4,
        ST_WRITE_COMMIT = 3'd5,
        ST_DONE         = 3'd6
    } state_e;

endpackage : spi_slave_pkg
`default_nettype wire

// File: rtl/spi_slave_core_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : shift_register
// Description : MSB-first shift register with parallel load. Shifts left by
//               one on shift_i, inserting sin_i at the LSB; load_i has
//               priority over shift_i.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset (clears contents)
//               load_i   - parallel load strobe (takes pdata_i)
//               shift_i  - shift-left strobe
//               sin_i    - serial input (enters at LSB)
//               pdata_i  - parallel load data
//               pdata_o  - parallel output, see note below
//               sout_o   - serial output (current MSB)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] pdata_i,
    output logic [WIDTH-1:0] pdata_o,
    output logic             sout_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= pdata_i;
        end else if (shift_i) begin
            data_q <= {data_q[WIDTH-2:0], sin_i};
        end
    end

    // The parallel output already includes the bit waiting on sin_i, so a
    // consumer capturing on the same edge as the final shift sees the
    // complete received word rather than one bit short.
    assign pdata_o = {data_q[WIDTH-2:0], sin_i};
    assign sout_o  = data_q[WIDTH-1];

endmodule : shift_register
`default_nettype wire

// File: rtl/spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_core
// Description : SPI slave register-access controller. A transaction is a
//               WIDTH-bit command frame {addr, rw} followed by a WIDTH-bit
//               data phase: writes shift data in and strobe mem_we once,
//               reads load mem_rdata and shift it out on miso.
// Ports       : clk, rst_n          - system clock, async active-low reset
//               cs_n, mosi          - conditioned chip select / serial in
//               sclk_pos, sclk_neg  - one-clk serial clock edge pulses
//               miso, miso_oe       - serial out and its tri-state enable
//               mem_addr, mem_wdata - registered memory address / write data
//               mem_we              - one-clk write strobe
//               mem_rdata           - memory read data
//               busy                - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_core
    import spi_slave_pkg::*;
#(
    parameter int unsigned WIDTH  = c_default_width,
    parameter int unsigned ADDR_W = c_default_addr_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              mosi,
    input  logic              sclk_pos,
    input  logic              sclk_neg,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy
);

    // One extra bit so the counter can never wrap inside a frame.
    localparam int unsigned            c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0]     c_last_bit = c_cnt_w'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;

    logic                sr_load;
    logic                sr_shift;
    logic                sr_sin;
    logic [WIDTH-1:0]    sr_frame;
    logic                sr_msb;

    logic                cnt_en;
    logic                last_pos;

    // WIDTH-th rising serial edge of the current frame.
    assign last_pos = sclk_pos && (cnt_q == c_last_bit);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if ((state_q != ST_IDLE) && cs_n) begin
            // Deselect aborts whatever is in flight.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:         if (!cs_n) state_d = ST_GET_ADDR;
                ST_GET_ADDR:     if (last_pos)
                                     state_d = sr_frame[0] ? ST_READ_LOAD
                                                           : ST_WRITE_SHIFT;
                ST_READ_LOAD:    state_d = ST_READ_SHIFT;
                ST_READ_SHIFT:   if (last_pos) state_d = ST_DONE;
                ST_WRITE_SHIFT:  if (last_pos) state_d = ST_WRITE_COMMIT;
                ST_WRITE_COMMIT: state_d = ST_DONE;
                ST_DONE:         state_d = ST_DONE;
                default:         state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q != ST_IDLE);
        miso_oe  = (state_q == ST_READ_SHIFT);
        miso     = miso_oe & sr_msb;
        mem_we   = (state_q == ST_WRITE_COMMIT);
        sr_load  = (state_q == ST_READ_LOAD);
        sr_shift = 1'b0;
        sr_sin   = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_GET_ADDR, ST_WRITE_SHIFT: begin
                sr_shift = sclk_pos;
                sr_sin   = mosi;
                cnt_en   = sclk_pos;
            end
            ST_READ_SHIFT: begin
                // A falling edge before the first rising edge of the data
                // phase is the one that presents the MSB, which the load has
                // already placed on miso; only later falling edges advance.
                // A falling edge coinciding with a rising edge is dropped.
                sr_shift = sclk_neg && !sclk_pos && (cnt_q != '0);
                cnt_en   = sclk_pos;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = last_pos ? '0 : cnt_q + 1'b1;
        end
        if ((state_q == ST_GET_ADDR) && last_pos && !cs_n) begin
            addr_d = sr_frame[WIDTH-1:1];
        end
        if ((state_q == ST_WRITE_SHIFT) && last_pos && !cs_n) begin
            wdata_d = sr_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // ------------------------------------------------------------------
    // Shift register
    // ------------------------------------------------------------------
    shift_register #(
        .WIDTH (WIDTH)
    ) u_shift_register (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .sin_i   (sr_sin),
        .pdata_i (mem_rdata),
        .pdata_o (sr_frame),
        .sout_o  (sr_msb)
    );

endmodule : spi_slave_core
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_core
// Description : Scoreboard bench for spi_slave_core. Stimulus pushes expected
//               memory writes and expected miso bits into queues; a monitor
//               pops and compares whenever the DUT strobes mem_we or the
//               master samples miso on a rising serial edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       mosi;
    logic       sclk_pos;
    logic       sclk_neg;
    logic       miso;
    logic       miso_oe;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    logic [14:0] exp_wr[$];   // {addr, data}
    logic        exp_bit[$];

    logic [7:0] mem [0:127];

    always #5 clk = ~clk;

    spi_slave_core #(
        .WIDTH  (8),
        .ADDR_W (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory model: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
                end else begin
                    logic [14:0] e;
                    e = exp_wr.pop_front();
                    chk("write_addr", {25'd0, mem_addr}, {25'd0, e[14:8]});
                    chk("write_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
                end
            end
            if (sclk_pos && miso_oe) begin
                if (exp_bit.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_miso: got bit %0b expected no read sample", miso);
                end else begin
                    logic eb;
                    eb = exp_bit.pop_front();
                    chk("miso_bit", {31'd0, miso}, {31'd0, eb});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One serial bit: rising edge pulse (optionally with a coincident falling
    // pulse), gap, falling edge pulse, gap -> 2 clk serial half-period.
    task automatic sbit(input logic b, input logic both);
        mosi     = b;
        sclk_pos = 1'b1;
        sclk_neg = both;
        tick();
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        tick();
        sclk_neg = 1'b1;
        tick();
        sclk_neg = 1'b0;
        tick();
    endtask

    task automatic sbyte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sbit(v[i], 1'b0);
    endtask

    task automatic push_bits(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) exp_bit.push_back(v[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_miso",    {31'd0, miso},    32'd0);
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_mem_we",  {31'd0, mem_we},  32'd0);
        chk("rst_addr",    {25'd0, mem_addr},  32'd0);
        chk("rst_wdata",   {24'd0, mem_wdata}, 32'd0);

        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_cs_high", {31'd0, busy}, 32'd0);

        // Write 0xC3 to address 0x2A (frame 0x54)
        exp_wr.push_back({7'h2A, 8'hC3});
        cs_n = 1'b0;
        tick();
        chk("busy_on_select", {31'd0, busy}, 32'd1);
        sbyte(8'h54);
        sbyte(8'hC3);
        chk("write_done_busy", {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        tick();
        chk("write_idle", {31'd0, busy}, 32'd0);
        chk("mem_2a", {24'd0, mem[7'h2A]}, 32'h0000_00C3);

        // Read address 0x2A (frame 0x55) -> 1,1,0,0,0,0,1,1
        push_bits(8'hC3);
        cs_n = 1'b0;
        tick();
        sbyte(8'h55);
        chk("read_oe",    {31'd0, miso_oe}, 32'd1);
        chk("read_addr",  {25'd0, mem_addr}, 32'h2A);
        sbyte(8'h00);
        chk("read_done_busy", {31'd0, busy},    32'd1);
        chk("read_done_oe",   {31'd0, miso_oe}, 32'd0);
        chk("read_done_miso", {31'd0, miso},    32'd0);
        cs_n = 1'b1;
        tick();
        chk("read_idle", {31'd0, busy}, 32'd0);

        // Read again with a coincident pos/neg pulse as the 6th rising edge:
        // the sample sequence is unchanged and the frame still ends on the 8th.
        push_bits(8'hC3);
        cs_n = 1'b0;
        tick();
        sbyte(8'h55);
        for (int i = 7; i >= 0; i--) sbit(1'b0, (i == 2));
        chk("both_done_busy", {31'd0, busy},    32'd1);
        chk("both_done_oe",   {31'd0, miso_oe}, 32'd0);
        cs_n = 1'b1;
        tick();

        // Abort a write to 0x10 after 4 data bits
        cs_n = 1'b0;
        tick();
        sbyte(8'h20);
        sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b1);
        sbit(1'b1, 1'b0);
        sbit(1'b0, 1'b0);
        cs_n = 1'b1;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        chk("abort_mem10", {24'd0, mem[7'h10]}, 32'd0);

        // Reset in the middle of a read
        exp_bit.push_back(1'b1);
        exp_bit.push_back(1'b1);
        exp_bit.push_back(1'b0);
        cs_n = 1'b0;
        tick();
        sbyte(8'h55);
        for (int i = 0; i < 3; i++) sbit(1'b0, 1'b0);
        chk("pre_rst_oe", {31'd0, miso_oe}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_oe",   {31'd0, miso_oe}, 32'd0);
        chk("async_rst_miso", {31'd0, miso},    32'd0);
        chk("async_rst_busy", {31'd0, busy},    32'd0);
        cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        cs_n = 1'b0;
        tick();
        chk("post_rst_select", {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        tick();
        chk("post_rst_deselect", {31'd0, busy}, 32'd0);

        // Back-to-back: write 0x01 to 0x00, deselect one clk, read 0x00
        exp_wr.push_back({7'h00, 8'h01});
        cs_n = 1'b0;
        tick();
        sbyte(8'h00);
        sbyte(8'h01);
        cs_n = 1'b1;
        tick();
        cs_n = 1'b0;
        push_bits(8'h01);
        tick();
        sbyte(8'h01);
        sbyte(8'h00);
        chk("b2b_done_busy", {31'd0, busy},    32'd1);
        chk("b2b_done_oe",   {31'd0, miso_oe}, 32'd0);
        cs_n = 1'b1;
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        repeat (4) tick();
        chk("wr_queue_drained",  exp_wr.size(),  32'd0);
        chk("bit_queue_drained", exp_bit.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_spi_slave_core
`default_nettype wire
